serial_bit_source: RTL and testbench

// - Parallel-in/serial-out stage feeding the lab5 sequence detector's single-bit input x, one bit per clk.
// - Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out as a registered bit stream.
// - Supports back-to-back words with no idle gap, so the detector sees continuous streams across word boundaries.

---
 rtl/ser_pkg.sv | 24 ++
 rtl/serial_bit_source_bit_counter.sv | 55 +++++
 rtl/serial_bit_source.sv | 192 +++++++++++++++++++
 tb/tb_serial_bit_source.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ============================================================================
//  Module   : ser_pkg
//  Purpose  : Shared definitions for the serial bit source: FSM state
//             encodings and the bit-counter width helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ser_pkg;

   // FSM state encodings (ST_PAR is only reachable when SER_PARITY_EN is set)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_PAR   = 2'd2;

   // Counter width able to hold 0..WIDTH, which covers a frame that carries
   // an extra parity bit after the WIDTH data bits.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : ser_pkg

`default_nettype wire

// File: rtl/serial_bit_source_bit_counter.sv
// ============================================================================
//  Module   : bit_counter
//  Purpose  : Bit position counter for the serializer. Supports synchronous
//             clear, load and increment; flags the last bit position
//             (FRAME_LEN-1) combinationally.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_counter #(
   parameter int CNT_W     = 4,
   parameter int FRAME_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   localparam logic [CNT_W-1:0] C_TC_VAL = CNT_W'(FRAME_LEN - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next-count selection: clear beats load, load beats increment
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = (count_q == C_TC_VAL);

endmodule : bit_counter

`default_nettype wire

// File: rtl/serial_bit_source.sv
// ============================================================================
//  Module   : serial_bit_source
//  Purpose  : Parallel-in / serial-out stage. Accepts a WIDTH-bit word over a
//             valid/ready handshake and emits it one registered bit per clock
//             on x_out, with bit_valid marking frame bits and done marking
//             the last bit. Back-to-back words stream with no idle gap.
//  Config   : SER_PARITY_EN - when defined, an even-parity bit (XOR of the
//             word) follows the data bits in state ST_PAR and becomes the
//             last bit of the frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_bit_source
   import ser_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             x_out,
   output logic             bit_valid,
   output logic             done,
   output logic [7:0]       frame_cnt
);

   localparam int CNT_W = cnt_w(WIDTH);
`ifdef SER_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [WIDTH-1:0] sr_q;        // bits still to be sent, next bit at the exit end
   logic [WIDTH-1:0] sr_d;
   logic             x_out_q;
   logic             x_out_d;
   logic [7:0]       frame_cnt_q;
   logic [7:0]       frame_cnt_d;
`ifdef SER_PARITY_EN
   logic             parity_q;
   logic             parity_d;
`endif

   // ---------------------------------------------------------------------
   // Bit counter interface
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] cnt;
   logic             cnt_tc;
   logic             cnt_clear;
   logic             cnt_load;
   logic             cnt_inc;

   // ---------------------------------------------------------------------
   // Handshake / frame status
   // ---------------------------------------------------------------------
   logic w_in_frame;
   logic w_last;
   logic w_accept;

   // Bit ordering helpers
   logic             w_first_bit;   // first bit of the incoming word
   logic [WIDTH-1:0] w_load_shift;  // incoming word with its first bit removed
   logic             w_next_bit;    // next bit waiting in the shift register
   logic [WIDTH-1:0] w_sr_shift;    // shift register after removing next bit

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_first_bit  = din[WIDTH-1];
         assign w_load_shift = {din[WIDTH-2:0], 1'b0};
         assign w_next_bit   = sr_q[WIDTH-1];
         assign w_sr_shift   = {sr_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_first_bit  = din[0];
         assign w_load_shift = {1'b0, din[WIDTH-1:1]};
         assign w_next_bit   = sr_q[0];
         assign w_sr_shift   = {1'b0, sr_q[WIDTH-1:1]};
      end
   endgenerate

   // A frame bit is on x_out whenever the FSM is outside IDLE; the counter
   // tracks which bit, so its terminal count marks the last frame bit.
   assign w_in_frame = (state_q != ST_IDLE);
   assign w_last     = w_in_frame & cnt_tc;
   assign load_ready = ~w_in_frame | w_last;
   assign w_accept   = load_valid & load_ready;

   // Next-state, datapath and counter-control decode
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      x_out_d     = x_out_q;
      frame_cnt_d = frame_cnt_q;
      cnt_clear   = 1'b0;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;
`ifdef SER_PARITY_EN
      parity_d    = parity_q;
`endif

      // A frame completes at the edge that ends its last-bit cycle,
      // regardless of whether a new word is accepted at the same edge.
      if (w_last) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end

      if (w_accept) begin
         // New word: first bit goes straight to x_out, the rest is queued.
         state_d  = ST_SHIFT;
         sr_d     = w_load_shift;
         x_out_d  = w_first_bit;
         cnt_load = 1'b1;
`ifdef SER_PARITY_EN
         parity_d = ^din;
`endif
      end else if (w_last) begin
         // Frame ends with nothing waiting: return the line to idle.
         state_d   = ST_IDLE;
         x_out_d   = IDLE_LEVEL;
         cnt_clear = 1'b1;
      end else if (w_in_frame) begin
         cnt_inc = 1'b1;
`ifdef SER_PARITY_EN
         if (cnt == CNT_W'(WIDTH - 1)) begin
            // All data bits sent; the parity bit closes the frame.
            state_d = ST_PAR;
            x_out_d = parity_q;
         end else begin
            x_out_d = w_next_bit;
            sr_d    = w_sr_shift;
         end
`else
         x_out_d = w_next_bit;
         sr_d    = w_sr_shift;
`endif
      end
   end

   // State and datapath registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         x_out_q     <= IDLE_LEVEL;
         frame_cnt_q <= 8'd0;
`ifdef SER_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         x_out_q     <= x_out_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef SER_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   // Bit position within the current frame
   bit_counter #(
      .CNT_W     (CNT_W),
      .FRAME_LEN (FRAME_LEN)
   ) u_bit_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .load_val ({CNT_W{1'b0}}),
      .inc      (cnt_inc),
      .count    (cnt),
      .tc       (cnt_tc)
   );

   assign x_out     = x_out_q;
   assign bit_valid = w_in_frame;
   assign done      = w_last;
   assign frame_cnt = frame_cnt_q;

endmodule : serial_bit_source

`default_nettype wire

// File: tb/tb_serial_bit_source.sv
// ============================================================================
//  Module   : tb_serial_bit_source
//  Purpose  : Directed self-checking bench for serial_bit_source. One
//             instance sends MSB first, a second sends LSB first.
//             Parity frames are exercised when SER_PARITY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_bit_source;

   logic       clk = 1'b0;
   logic       rst;

   // MSB-first instance
   logic [7:0] din_m;
   logic       lv_m;
   logic       ready_m;
   logic       x_m;
   logic       bv_m;
   logic       done_m;
   logic [7:0] fc_m;

   // LSB-first instance
   logic [7:0] din_l;
   logic       lv_l;
   logic       ready_l;
   logic       x_l;
   logic       bv_l;
   logic       done_l;
   logic [7:0] fc_l;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_bit_source #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
      .clk        (clk),
      .rst        (rst),
      .din        (din_m),
      .load_valid (lv_m),
      .load_ready (ready_m),
      .x_out      (x_m),
      .bit_valid  (bv_m),
      .done       (done_m),
      .frame_cnt  (fc_m)
   );

   serial_bit_source #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
      .clk        (clk),
      .rst        (rst),
      .din        (din_l),
      .load_valid (lv_l),
      .load_ready (ready_l),
      .x_out      (x_l),
      .bit_valid  (bv_l),
      .done       (done_l),
      .frame_cnt  (fc_l)
   );

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  exp8;
      logic [15:0] exp16;
      int          dones;
      int          budget;

      rst   = 1'b1;
      lv_m  = 1'b1;    // valid held during reset must be ignored
      din_m = 8'hFF;
      lv_l  = 1'b0;
      din_l = 8'h00;

      // ---------------- reset ----------------
      tick();
      tick();
      check("rst_x",     x_m,    0);
      check("rst_bv",    bv_m,   0);
      check("rst_done",  done_m, 0);
      check("rst_fcnt",  fc_m,   0);
      rst  = 1'b0;
      lv_m = 1'b0;
      check("rst_ready", ready_m, 1);
      tick();
      check("rst_idle_bv", bv_m, 0);

      // ---------------- reset mid-frame ----------------
      din_m = 8'hFF;
      lv_m  = 1'b1;
      tick();
      lv_m  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("mid_x%0d", i),  x_m,  1);
         check($sformatf("mid_bv%0d", i), bv_m, 1);
         check($sformatf("mid_rdy%0d", i), ready_m, 0);
         tick();
      end
      rst = 1'b1;           // asserted in the cycle carrying bit 4
      tick();
      rst = 1'b0;
      check("mid_rst_x",    x_m,    0);
      check("mid_rst_bv",   bv_m,   0);
      check("mid_rst_fcnt", fc_m,   0);
      check("mid_rst_rdy",  ready_m, 1);

      // ---------------- single word, MSB first ----------------
      exp8  = 8'b0101_0100;
      din_m = 8'b0101_0100;
      lv_m  = 1'b1;
      tick();
      lv_m  = 1'b0;
      din_m = 8'hFF;        // changing din after accept must not matter
      for (int i = 0; i < 8; i++) begin
         check($sformatf("msb_x%0d", i),    x_m,    exp8[7-i]);
         check($sformatf("msb_bv%0d", i),   bv_m,   1);
         check($sformatf("msb_done%0d", i), done_m, (i == 7) ? 1 : 0);
         tick();
      end
      check("msb_end_bv",   bv_m, 0);
      check("msb_end_x",    x_m,  0);
      check("msb_end_fcnt", fc_m, 1);

      // ---------------- back-to-back F0 then 0F ----------------
      exp16 = 16'b1111_0000_0000_1111;
      din_m = 8'hF0;
      lv_m  = 1'b1;
      tick();
      din_m = 8'h0F;        // held with valid until accepted at bit 8
      for (int i = 0; i < 16; i++) begin
         check($sformatf("b2b_x%0d", i),    x_m,    exp16[15-i]);
         check($sformatf("b2b_bv%0d", i),   bv_m,   1);
         check($sformatf("b2b_done%0d", i), done_m, (i == 7 || i == 15) ? 1 : 0);
         if (i == 3) check("b2b_rdy_mid", ready_m, 0);
         if (i == 7) check("b2b_rdy_last", ready_m, 1);
         tick();
         if (i == 7) lv_m = 1'b0;
      end
      check("b2b_end_bv",   bv_m, 0);
      check("b2b_end_fcnt", fc_m, 3);

`ifdef SER_PARITY_EN
      // ---------------- parity frames ----------------
      exp16 = {7'd0, 9'b0_0000_0111_1};
      din_m = 8'b0000_0111;
      lv_m  = 1'b1;
      tick();
      lv_m  = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("par07_x%0d", i),    x_m,    exp16[8-i]);
         check($sformatf("par07_done%0d", i), done_m, (i == 8) ? 1 : 0);
         tick();
      end
      check("par07_end_bv", bv_m, 0);

      exp16 = {7'd0, 9'b0_0000_0110};
      din_m = 8'h03;
      lv_m  = 1'b1;
      tick();
      lv_m  = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("par03_x%0d", i),    x_m,    exp16[8-i]);
         check($sformatf("par03_done%0d", i), done_m, (i == 8) ? 1 : 0);
         tick();
      end
      check("par03_end_bv",   bv_m, 0);
      check("par03_end_fcnt", fc_m, 5);
`endif

      // ---------------- LSB first ----------------
      exp8  = 8'b1010_0101;   // A5 sent LSB first: 1,0,1,0,0,1,0,1
      din_l = 8'hA5;
      lv_l  = 1'b1;
      tick();
      lv_l  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("lsb_x%0d", i),  x_l,  exp8[i]);
         check($sformatf("lsb_bv%0d", i), bv_l, 1);
         tick();
      end
      check("lsb_end_bv",   bv_l, 0);
      check("lsb_end_fcnt", fc_l, 1);

      // ---------------- frame counter wrap 255 -> 0 ----------------
      din_l  = 8'h3C;
      lv_l   = 1'b1;
      dones  = 0;
      budget = 3000;
      tick();
      while (dones < 255 && budget > 0) begin
         if (done_l) begin
            dones++;
            if (dones == 255) lv_l = 1'b0;
         end
         if (dones < 255) tick();
         budget--;
      end
      check("wrap_budget", (budget > 0) ? 1 : 0, 1);
      tick();
      check("wrap_fcnt", fc_l, 0);
      check("wrap_bv",   bv_l, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_serial_bit_source

`default_nettype wire
